// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner: FSM state encoding,
// special key codes, the row/column to key-code map and row-pattern helpers.
// No ports; imported by keypad_scanner.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } state_e;

  localparam logic [3:0] KEY_STAR  = 4'hE;
  localparam logic [3:0] KEY_HASH  = 4'hF;
  // Rows are active-low with external pull-ups: all high means no key on the driven column.
  localparam logic [3:0] ROWS_IDLE = 4'hF;

  // Physical layout:  r0: 1 2 3 A | r1: 4 5 6 B | r2: 7 8 9 C | r3: * 0 # D
  function automatic logic [3:0] key_lookup(input logic [1:0] row_idx,
                                            input logic [1:0] col_idx);
    logic [3:0] code;
    code = 4'h0;
    case ({row_idx, col_idx})
      4'h0: code = 4'h1;
      4'h1: code = 4'h2;
      4'h2: code = 4'h3;
      4'h3: code = 4'hA;
      4'h4: code = 4'h4;
      4'h5: code = 4'h5;
      4'h6: code = 4'h6;
      4'h7: code = 4'hB;
      4'h8: code = 4'h7;
      4'h9: code = 4'h8;
      4'hA: code = 4'h9;
      4'hB: code = 4'hC;
      4'hC: code = KEY_STAR;
      4'hD: code = 4'h0;
      4'hE: code = KEY_HASH;
      4'hF: code = 4'hD;
      default: code = 4'h0;
    endcase
    return code;
  endfunction

  // True when exactly one row is pulled low; zero or several low rows
  // (no key, or a ghosting/multi-key pattern) are rejected.
  function automatic logic onehot0_low(input logic [3:0] rs);
    logic [3:0] low;
    low = ~rs;
    return (low != 4'h0) && ((low & (low - 4'h1)) == 4'h0);
  endfunction

  // Index of the low row; only meaningful when onehot0_low() holds.
  function automatic logic [1:0] low_row_idx(input logic [3:0] rs);
    logic [1:0] idx;
    idx = 2'd0;
    if (!rs[0])      idx = 2'd0;
    else if (!rs[1]) idx = 2'd1;
    else if (!rs[2]) idx = 2'd2;
    else if (!rs[3]) idx = 2'd3;
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad-side and key-event signals of the scanner, bundled for port lists.
// master: the scanner (reads row_in, drives column and key outputs).
// slave:  the keypad/consumer side (drives row_in, observes the rest).
interface keypad_scanner_if;

  logic [3:0] row_in;     // active-low rows from the matrix, asynchronous
  logic [3:0] col_out;    // active-low column drive, one bit low
  logic [3:0] key_code;   // last accepted key
  logic       key_valid;  // one-cycle strobe per accepted press
  logic       key_held;   // accepted press not yet released

  modport master (
    input  row_in,
    output col_out,
    output key_code,
    output key_valid,
    output key_held
  );

  modport slave (
    output row_in,
    input  col_out,
    input  key_code,
    input  key_valid,
    input  key_held
  );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a bus of independent asynchronous bits.
// Latency: 2 cycles. No backpressure; the input is sampled every cycle.
// Ports: clk, rst (sync, active-high, loads RST_VAL), d (async in), q (synchronised out).
module sync_2ff #(
  parameter int               WIDTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q, meta_d;
  logic [WIDTH-1:0] sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// Scans a 4x4 active-low keypad, debounces press and release, emits one key code per press.
// Latency: <= 2 (sync) + SCAN_TICKS + DEBOUNCE_CYCLES + 1 cycles from a stable press on the driven column.
// Backpressure: none; key_valid is a one-cycle strobe that the consumer must take when it fires.
// Ports: clk, rst (sync, active-high); kp (master): row_in in, col_out/key_code/key_valid/key_held out.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_TICKS      = 1000,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic                    clk,
  input  logic                    rst,
  keypad_scanner_if.master        kp
);

  localparam int SW = $clog2(SCAN_TICKS) + 1;
  localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_TICKS - 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);

  logic [3:0] rs;  // synchronised rows

  sync_2ff #(
    .WIDTH   (4),
    .RST_VAL (4'hF)
  ) u_row_sync (
    .clk (clk),
    .rst (rst),
    .d   (kp.row_in),
    .q   (rs)
  );

  state_e        state_q,    state_d;
  logic [1:0]    col_idx_q,  col_idx_d;
  logic [3:0]    col_out_q,  col_out_d;
  logic [SW-1:0] scan_cnt_q, scan_cnt_d;
  logic [DW-1:0] dcnt_q,     dcnt_d;
  logic [3:0]    cand_q,     cand_d;      // row pattern that started the debounce
  logic [3:0]    key_code_q, key_code_d;
  logic          key_valid_q, key_valid_d;
  logic          key_held_q,  key_held_d;

  always_comb begin
    state_d     = state_q;
    col_idx_d   = col_idx_q;
    scan_cnt_d  = scan_cnt_q;
    dcnt_d      = dcnt_q;
    cand_d      = cand_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;

    case (state_q)
      SCAN: begin
        // Dwell on the column long enough for the new drive to reach rs
        // through the synchroniser before the rows are judged.
        if (scan_cnt_q == SCAN_LAST) begin
          scan_cnt_d = '0;
          if (onehot0_low(rs)) begin
            cand_d  = rs;
            dcnt_d  = '0;
            state_d = DEBOUNCE;
          end else begin
            col_idx_d = col_idx_q + 2'd1;
          end
        end else begin
          scan_cnt_d = scan_cnt_q + 1'b1;
        end
      end

      DEBOUNCE: begin
        // The press is accepted on the DEBOUNCE_CYCLES-th consecutive matching cycle.
        if (rs != cand_q) begin
          state_d    = SCAN;
          col_idx_d  = col_idx_q + 2'd1;
          scan_cnt_d = '0;
          dcnt_d     = '0;
        end else if (dcnt_q == DEB_LAST) begin
          state_d     = PRESSED;
          key_code_d  = key_lookup(low_row_idx(cand_q), col_idx_q);
          key_valid_d = 1'b1;
          key_held_d  = 1'b1;
          dcnt_d      = '0;
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end

      PRESSED: begin
        // Column stays frozen; further keys on this column are ignored
        // until every row reads released.
        if (rs == ROWS_IDLE) begin
          state_d = RELEASE;
          dcnt_d  = '0;
        end
      end

      RELEASE: begin
        if (rs != ROWS_IDLE) begin
          state_d = PRESSED;
          dcnt_d  = '0;
        end else if (dcnt_q == DEB_LAST) begin
          state_d    = SCAN;
          key_held_d = 1'b0;
          col_idx_d  = col_idx_q + 2'd1;
          scan_cnt_d = '0;
          dcnt_d     = '0;
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end

      default: begin
        state_d    = SCAN;
        scan_cnt_d = '0;
        dcnt_d     = '0;
      end
    endcase

    col_out_d = ~(4'b0001 << col_idx_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SCAN;
      col_idx_q   <= 2'd0;
      col_out_q   <= 4'b1110;
      scan_cnt_q  <= '0;
      dcnt_q      <= '0;
      cand_q      <= 4'hF;
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_idx_q   <= col_idx_d;
      col_out_q   <= col_out_d;
      scan_cnt_q  <= scan_cnt_d;
      dcnt_q      <= dcnt_d;
      cand_q      <= cand_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

  assign kp.col_out   = col_out_q;
  assign kp.key_code  = key_code_q;
  assign kp.key_valid = key_valid_q;
  assign kp.key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner with SCAN_TICKS=4, DEBOUNCE_CYCLES=8. The keypad matrix is
// modelled as a set of pressed keys; a row reads low when a pressed key on it sits on
// the column currently driven low.
module tb_keypad_scanner;

  localparam int SCAN = 4;
  localparam int DEB  = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  keypad_scanner_if kp_if ();

  keypad_scanner #(
    .SCAN_TICKS      (SCAN),
    .DEBOUNCE_CYCLES (DEB)
  ) dut (
    .clk (clk),
    .rst (rst),
    .kp  (kp_if)
  );

  // Matrix model: pressed[r*4+c] set while key (r,c) is held down.
  logic [15:0] pressed;
  logic [3:0]  row_v;
  always_comb begin
    row_v = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && (kp_if.col_out[c] === 1'b0)) row_v[r] = 1'b0;
  end
  assign kp_if.row_in = row_v;

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- continuous monitor (negedge sampling) ----------------
  logic rst_at_edge;
  always @(posedge clk) rst_at_edge <= rst;

  bit         mon_en = 0;
  int         pulse_cnt = 0;
  int         since_pulse = 1000000;
  logic       prev_valid = 1'b0;
  logic [3:0] prev_code = 4'h0;
  int         viol_consec = 0, viol_space = 0, viol_code = 0, viol_col = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (rst_at_edge) begin
        since_pulse = 1000000;
        prev_valid  = 1'b0;
        prev_code   = kp_if.key_code;
      end else begin
        if ($countones(~kp_if.col_out) != 1) viol_col++;
        if (kp_if.key_valid) begin
          pulse_cnt++;
          if (prev_valid) viol_consec++;
          if (since_pulse + 1 < 2*DEB + SCAN) viol_space++;
          since_pulse = 0;
        end else begin
          if (kp_if.key_code != prev_code) viol_code++;
          since_pulse++;
        end
        prev_valid = kp_if.key_valid;
        prev_code  = kp_if.key_code;
      end
    end
  end

  // ---------------- reference key map ----------------
  string keymap = "123A456B789C*0#D";
  function automatic int model_code(input int r, input int c);
    byte ch;
    ch = keymap[r*4 + c];
    if (ch == "*") return 14;
    if (ch == "#") return 15;
    if (ch >= "0" && ch <= "9") return int'(ch - "0");
    return int'(ch - "A") + 10;
  endfunction

  task automatic wait_valid(input int budget, output bit found, output int waited);
    found  = 0;
    waited = 0;
    while (!found && waited < budget) begin
      tick(1);
      waited++;
      if (kp_if.key_valid === 1'b1) found = 1;
    end
  endtask

  task automatic run_key(input int r, input int c, input int hold, input int idle,
                         output int pulses);
    int p0;
    p0 = pulse_cnt;
    pressed[r*4+c] = 1'b1;
    tick(hold);
    pressed = '0;
    tick(idle);
    pulses = pulse_cnt - p0;
  endtask

  typedef struct {
    int         row;
    int         col;
    int         hold;
    int         exp_pulses;
    logic [3:0] exp_code;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passed, total);
    $fatal(1);
  end

  initial begin
    bit   found;
    int   w, p0, pulses, k, r, c, nb;
    bit   held_drop;

    vecs[0] = '{row: 3, col: 0, hold: 60, exp_pulses: 1, exp_code: 4'hE};  // '*'
    vecs[1] = '{row: 3, col: 2, hold: 60, exp_pulses: 1, exp_code: 4'hF};  // '#'
    vecs[2] = '{row: 3, col: 3, hold: 60, exp_pulses: 1, exp_code: 4'hD};  // 'D'
    vecs[3] = '{row: 0, col: 3, hold: 5,  exp_pulses: 0, exp_code: 4'hD};  // 'A' too short
    vecs[4] = '{row: 1, col: 1, hold: 60, exp_pulses: 1, exp_code: 4'h5};  // '5'
    vecs[5] = '{row: 0, col: 2, hold: 45, exp_pulses: 1, exp_code: 4'h3};  // '3'

    pressed = '0;
    rst = 1'b1;
    tick(3);
    chk("reset_col_out",   kp_if.col_out,   4'b1110);
    chk("reset_key_code",  kp_if.key_code,  0);
    chk("reset_key_valid", kp_if.key_valid, 0);
    chk("reset_key_held",  kp_if.key_held,  0);
    rst = 1'b0;
    mon_en = 1;
    tick(2);

    // Steady press of '6', then release with key_held timing.
    p0 = pulse_cnt;
    pressed[1*4+2] = 1'b1;
    wait_valid(40, found, w);
    chk("t1_valid_seen", found, 1);
    chk("t1_code", kp_if.key_code, 4'h6);
    chk("t1_held_at_pulse", kp_if.key_held, 1);
    tick(60 - w);
    pressed = '0;
    tick(9);
    chk("t1_held_after_release", kp_if.key_held, 1);
    tick(5);
    chk("t1_held_cleared", kp_if.key_held, 0);
    tick(30);
    chk("t1_pulses", pulse_cnt - p0, 1);

    // Table of single presses.
    for (int i = 0; i < 6; i++) begin
      run_key(vecs[i].row, vecs[i].col, vecs[i].hold, 40, pulses);
      chk($sformatf("vec%0d_pulses", i), pulses, vecs[i].exp_pulses);
      chk($sformatf("vec%0d_code", i), kp_if.key_code, vecs[i].exp_code);
      chk($sformatf("vec%0d_held", i), kp_if.key_held, 0);
    end

    // '1' and '4' together on column 0: rejected until '4' lets go.
    p0 = pulse_cnt;
    pressed[0*4+0] = 1'b1;
    pressed[1*4+0] = 1'b1;
    tick(60);
    chk("t3_multi_no_pulse", pulse_cnt - p0, 0);
    pressed[1*4+0] = 1'b0;
    tick(60);
    chk("t3_single_pulse", pulse_cnt - p0, 1);
    chk("t3_code", kp_if.key_code, 4'h1);
    pressed = '0;
    tick(40);
    chk("t3_held_cleared", kp_if.key_held, 0);

    // '9' held 200 cycles with two 3-cycle release glitches.
    p0 = pulse_cnt;
    held_drop = 0;
    for (int i = 0; i < 200; i++) begin
      pressed[2*4+2] = !((i >= 80 && i < 83) || (i >= 150 && i < 153));
      tick(1);
      if (i >= 60 && kp_if.key_held !== 1'b1) held_drop = 1;
    end
    pressed = '0;
    tick(40);
    chk("t4_held_through_glitches", held_drop, 0);
    chk("t4_pulses", pulse_cnt - p0, 1);
    chk("t4_code", kp_if.key_code, 4'h9);

    // Reset while PRESSED, key still held.
    pressed[1*4+1] = 1'b1;
    wait_valid(40, found, w);
    chk("t5_valid_seen", found, 1);
    tick(3);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("t5_rst_col_out",   kp_if.col_out,   4'b1110);
    chk("t5_rst_key_code",  kp_if.key_code,  0);
    chk("t5_rst_key_held",  kp_if.key_held,  0);
    chk("t5_rst_key_valid", kp_if.key_valid, 0);
    p0 = pulse_cnt;
    tick(DEB);
    chk("t5_no_early_retrigger", pulse_cnt - p0, 0);
    wait_valid(40, found, w);
    chk("t5_retrigger", found, 1);
    chk("t5_retrigger_code", kp_if.key_code, 4'h5);
    pressed = '0;
    tick(40);

    // Bouncing '0': 5 low / 3 high, three times, then a stable hold.
    p0 = pulse_cnt;
    for (int i = 0; i < 3; i++) begin
      pressed[3*4+1] = 1'b1;
      tick(5);
      pressed[3*4+1] = 1'b0;
      tick(3);
    end
    chk("t2_bounce_no_pulse", pulse_cnt - p0, 0);
    run_key(3, 1, 40, 40, pulses);
    chk("t2_pulses", pulse_cnt - p0, 1);
    chk("t2_code", kp_if.key_code, 4'h0);

    // Randomised presses with optional short bounces against the key-map model.
    for (int it = 0; it < 10; it++) begin
      k = $urandom_range(0, 15);
      r = k / 4;
      c = k % 4;
      p0 = pulse_cnt;
      nb = $urandom_range(0, 2);
      for (int b = 0; b < nb; b++) begin
        pressed[k] = 1'b1;
        tick($urandom_range(1, 6));
        pressed[k] = 1'b0;
        tick($urandom_range(1, 4));
      end
      run_key(r, c, $urandom_range(40, 80), 40, pulses);
      chk($sformatf("rand%0d_pulses key%0d", it, k), pulse_cnt - p0, 1);
      chk($sformatf("rand%0d_code key%0d", it, k), kp_if.key_code, model_code(r, c));
    end

    chk("inv_col_one_low",       viol_col,    0);
    chk("inv_valid_not_back2back", viol_consec, 0);
    chk("inv_pulse_spacing",     viol_space,  0);
    chk("inv_code_stable",       viol_code,   0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
